// File: rtl/inst_rom_resp.sv
// ---------------------------------------------------------------------------------------------
// inst_rom_resp
//   Instruction-memory responder on the fetch side of the PC interface.
//
//   This block accepts one fetch request (i_ce, i_addr) per cycle while in RUN. It returns the
//   addressed 32-bit word LATENCY cycles later, in request order, with o_inst_valid set.
//   A misaligned or out-of-range fetch still gets a response at the normal latency. That
//   response carries NOP_WORD with o_fetch_err set.
//
//   A RUN/DRAIN/LOAD state machine keeps fetch and program load mutually exclusive. Raising
//   i_ld_req stops new fetches. The block waits for the response pipeline to empty and then
//   opens the word-wide load port (valid/ready) used by the debug/boot path.
//
// Ports
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_ce, i_addr        fetch request enable and byte address
//   o_inst              fetched word (holds last value while o_inst_valid=0)
//   o_inst_valid        o_inst / o_fetch_err valid this cycle
//   o_fetch_err         response was misaligned or out of range
//   o_fetch_stall       1 whenever state != RUN; fetches are not accepted
//   i_ld_req            level request for load mode
//   i_ld_valid          load word present
//   o_ld_ready          high in LOAD; word accepted on i_ld_valid & o_ld_ready
//   i_ld_addr/i_ld_data byte address and data of the load word
//   o_ld_err            one-cycle pulse: an accepted load word was dropped (bad address)
// ---------------------------------------------------------------------------------------------
module inst_rom_resp #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2,   // legal 1..4
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ce,
    input  logic [31:0] i_addr,
    output logic [31:0] o_inst,
    output logic        o_inst_valid,
    output logic        o_fetch_err,
    output logic        o_fetch_stall,
    input  logic        i_ld_req,
    input  logic        i_ld_valid,
    output logic        o_ld_ready,
    input  logic [31:0] i_ld_addr,
    input  logic [31:0] i_ld_data,
    output logic        o_ld_err
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {StRun, StDrain, StLoad} state_e;

    state_e                  r_state;
    state_e                  w_state_next;

    logic [31:0]             r_mem [Depth];
    logic [LATENCY-1:0]      r_vld;
    logic [LATENCY-1:0]      r_err;
    logic [31:0]             r_data [LATENCY];
    logic                    r_ld_err;

    logic                    w_accept;
    logic                    w_fetch_bad;
    logic [DEPTH_LOG2-1:0]   w_fetch_idx;
    logic                    w_ld_fire;
    logic                    w_ld_bad;
    logic                    w_ld_we;
    logic [DEPTH_LOG2-1:0]   w_ld_idx;

    assign w_fetch_idx = i_addr[DEPTH_LOG2+1:2];
    assign w_fetch_bad = (i_addr[1:0] != 2'b00) || (i_addr[31:DEPTH_LOG2+2] != '0);
    assign w_accept    = i_ce && (r_state == StRun);

    assign w_ld_idx  = i_ld_addr[DEPTH_LOG2+1:2];
    assign w_ld_bad  = (i_ld_addr[1:0] != 2'b00) || (i_ld_addr[31:DEPTH_LOG2+2] != '0);
    assign w_ld_fire = i_ld_valid && (r_state == StLoad);
    assign w_ld_we   = w_ld_fire && !w_ld_bad;

    // State machine: next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StRun: begin
                // A fetch presented alongside i_ld_req is still accepted this cycle
                if (i_ld_req) w_state_next = StDrain;
            end
            StDrain: begin
                if (r_vld == '0) w_state_next = i_ld_req ? StLoad : StRun;
            end
            StLoad: begin
                if (!i_ld_req) w_state_next = StRun;
            end
            default: w_state_next = StRun;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StRun;
            r_ld_err <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_ld_err <= w_ld_fire && w_ld_bad;
        end
    end

    // Memory contents survive reset, so the array has no reset branch
    always_ff @(posedge i_clk) begin
        if (w_ld_we) r_mem[w_ld_idx] <= i_ld_data;
    end

    // Response pipeline. Stage 0 holds the registered read; later stages are pure delay.
    // Each data stage only advances on a valid slot, so the output holds across bubbles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= '0;
            r_err <= '0;
            for (int i = 0; i < LATENCY; i++) r_data[i] <= '0;
        end else begin
            r_vld[0] <= w_accept;
            r_err[0] <= w_accept && w_fetch_bad;
            if (w_accept) r_data[0] <= w_fetch_bad ? NOP_WORD : r_mem[w_fetch_idx];
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_err[i] <= r_err[i-1];
                if (r_vld[i-1]) r_data[i] <= r_data[i-1];
            end
        end
    end

    assign o_inst        = r_data[LATENCY-1];
    assign o_inst_valid  = r_vld[LATENCY-1];
    assign o_fetch_err   = r_vld[LATENCY-1] && r_err[LATENCY-1];
    assign o_fetch_stall = (r_state != StRun);
    assign o_ld_ready    = (r_state == StLoad);
    assign o_ld_err      = r_ld_err;

endmodule
